dyt_load_store_unit: RTL and testbench

Memory-side responder for the CPU's load/store request interface. It accepts instruction-fetch, data-read and data-write requests, serialises them onto a single-port SRAM bus, and returns read data plus per-source one-cycle grants. Sits between the CPU core (initiator modport) and the SRAM model/controller.

---
 rtl/common_types.sv | 24 ++
 rtl/dyt_load_store_unit_if.sv | 25 ++
 rtl/dyt_lsu_byte_lane.sv | 32 +++
 rtl/dyt_load_store_unit.sv | 148 ++++++++++++++
 tb/tb_dyt_load_store_unit.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/common_types.sv
// Shared types for the load/store unit: store width, FSM state and request source.
package common_types;

   typedef enum logic [1:0] {
      LSU_W_BYTE = 2'd0,
      LSU_W_HALF = 2'd1,
      LSU_W_WORD = 2'd2
   } lsu_mem_w_type_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      GRANT  = 2'd2
   } lsu_state_t;

   typedef enum logic [1:0] {
      SRC_I  = 2'd0,
      SRC_DR = 2'd1,
      SRC_DW = 2'd2
   } lsu_src_t;

   localparam logic [31:0] LSU_ABORT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/dyt_load_store_unit_if.sv
// CPU-side load/store request bus; the CPU drives requests (master), the LSU answers (slave).
interface dyt_load_store_unit_if;
   import common_types::*;

   logic [31:0]     mem_address;
   logic [31:0]     mem_w_data;
   logic            mem_d_ren;
   logic            mem_i_ren;
   logic            mem_wen;
   lsu_mem_w_type_t mem_w_type;
   logic [31:0]     mem_r_data;
   logic            mem_d_gnt;
   logic            mem_i_gnt;

   modport master (
      output mem_address, mem_w_data, mem_d_ren, mem_i_ren, mem_wen, mem_w_type,
      input  mem_r_data, mem_d_gnt, mem_i_gnt
   );

   modport slave (
      input  mem_address, mem_w_data, mem_d_ren, mem_i_ren, mem_wen, mem_w_type,
      output mem_r_data, mem_d_gnt, mem_i_gnt
   );

endinterface

// File: rtl/dyt_lsu_byte_lane.sv
// Combinational byte-enable and lane-replicated store data; reads always enable all four lanes.
module dyt_lsu_byte_lane
   import common_types::*;
(
   input  lsu_mem_w_type_t w_type,
   input  logic [1:0]      addr,
   input  logic [31:0]     w_data,
   input  logic            wr,
   output logic [3:0]      ben,
   output logic [31:0]     wdata
);

   always_comb begin
      ben   = 4'b1111;
      wdata = w_data;
      case (w_type)
         LSU_W_BYTE: begin
            ben   = 4'b0001 << addr;
            wdata = {4{w_data[7:0]}};
         end
         LSU_W_HALF: begin
            ben   = addr[1] ? 4'b1100 : 4'b0011;
            wdata = {2{w_data[15:0]}};
         end
         default: ;
      endcase
      if (!wr) begin
         ben = 4'b1111;
      end
   end

endmodule

// File: rtl/dyt_load_store_unit.sv
// Serialises fetch/read/write requests onto a single-port SRAM; grant 1 cycle after sram_ready, one access per 3 cycles.
// Requests are level-held until granted; LSU_TIMEOUT_EN adds an ACCESS timeout with lsu_err and 0xDEADBEEF data.
module dyt_load_store_unit
   import common_types::*;
#(
   parameter int SRAM_TIMEOUT = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   dyt_load_store_unit_if.slave bus,
   output logic [31:0]          sram_addr,
   output logic [31:0]          sram_wdata,
   output logic [3:0]           sram_ben,
   output logic                 sram_ren,
   output logic                 sram_wen,
   input  logic [31:0]          sram_rdata,
`ifdef LSU_TIMEOUT_EN
   input  logic                 sram_ready,
   output logic                 lsu_err
`else
   input  logic                 sram_ready
`endif
);

   lsu_state_t  state, state_nxt;
   lsu_src_t    src, arb_src;
   logic        req_any;
   logic        src_req;
   logic        timeout_hit;
   logic        access_done;
   logic        grant_ok;
   logic [3:0]  lane_ben;
   logic [31:0] lane_wdata;

   dyt_lsu_byte_lane u_lane (
      .w_type (bus.mem_w_type),
      .addr   (bus.mem_address[1:0]),
      .w_data (bus.mem_w_data),
      .wr     (bus.mem_wen),
      .ben    (lane_ben),
      .wdata  (lane_wdata)
   );

   always_comb begin
      req_any = bus.mem_wen | bus.mem_d_ren | bus.mem_i_ren;
      arb_src = SRC_I;
      if (bus.mem_wen) begin
         arb_src = SRC_DW;
      end else if (bus.mem_d_ren) begin
         arb_src = SRC_DR;
      end
      // A source that let go of its request mid-access gets no grant.
      case (src)
         SRC_DW:  src_req = bus.mem_wen;
         SRC_DR:  src_req = bus.mem_d_ren;
         default: src_req = bus.mem_i_ren;
      endcase
   end

`ifdef LSU_TIMEOUT_EN
   localparam int CNT_W = $clog2(SRAM_TIMEOUT + 1);
   logic [CNT_W-1:0] cnt;

   assign timeout_hit = (state == ACCESS) && !sram_ready &&
                        (cnt == CNT_W'(SRAM_TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         lsu_err <= 1'b0;
      end else begin
         lsu_err <= timeout_hit;
         if (state == IDLE) begin
            cnt <= '0;
         end else if (state == ACCESS) begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   assign access_done = sram_ready | timeout_hit;
   assign grant_ok    = sram_ready ? src_req : 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req_any) state_nxt = ACCESS;
         ACCESS:  if (access_done) state_nxt = GRANT;
         GRANT:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         src            <= SRC_I;
         sram_addr      <= '0;
         sram_wdata     <= '0;
         sram_ben       <= '0;
         sram_ren       <= 1'b0;
         sram_wen       <= 1'b0;
         bus.mem_r_data <= '0;
         bus.mem_d_gnt  <= 1'b0;
         bus.mem_i_gnt  <= 1'b0;
      end else begin
         bus.mem_d_gnt <= 1'b0;
         bus.mem_i_gnt <= 1'b0;
         case (state)
            IDLE: begin
               if (req_any) begin
                  src        <= arb_src;
                  sram_addr  <= {bus.mem_address[31:2], 2'b00};
                  sram_ben   <= lane_ben;
                  sram_wdata <= lane_wdata;
                  sram_wen   <= bus.mem_wen;
                  sram_ren   <= ~bus.mem_wen;
               end
            end
            ACCESS: begin
               if (access_done) begin
                  sram_ren      <= 1'b0;
                  sram_wen      <= 1'b0;
                  bus.mem_i_gnt <= grant_ok && (src == SRC_I);
                  bus.mem_d_gnt <= grant_ok && (src != SRC_I);
                  if (!sram_ready) begin
                     bus.mem_r_data <= LSU_ABORT_DATA;
                  end else if (src != SRC_DW) begin
                     bus.mem_r_data <= sram_rdata;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dyt_load_store_unit.sv
// Directed bench for dyt_load_store_unit: arbitration, lane generation, latency, drop/reset handling.
module tb_dyt_load_store_unit;
   import common_types::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] sram_addr, sram_wdata, sram_rdata;
   logic [3:0]  sram_ben;
   logic        sram_ren, sram_wen, sram_ready;
`ifdef LSU_TIMEOUT_EN
   logic        lsu_err;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   dyt_load_store_unit_if bus ();

   dyt_load_store_unit #(.SRAM_TIMEOUT(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .sram_addr  (sram_addr),
      .sram_wdata (sram_wdata),
      .sram_ben   (sram_ben),
      .sram_ren   (sram_ren),
      .sram_wen   (sram_wen),
      .sram_rdata (sram_rdata),
`ifdef LSU_TIMEOUT_EN
      .sram_ready (sram_ready),
      .lsu_err    (lsu_err)
`else
      .sram_ready (sram_ready)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Waits up to budget negedges for a grant; at = cycle count when seen, -1 if never.
   task automatic wait_gnt(input bit data, input int budget, output int at);
      at = -1;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         if (data ? bus.mem_d_gnt : bus.mem_i_gnt) begin
            at = cyc;
            break;
         end
      end
   endtask

   task automatic idle_bus();
      bus.mem_i_ren = 1'b0;
      bus.mem_d_ren = 1'b0;
      bus.mem_wen   = 1'b0;
      sram_ready    = 1'b0;
   endtask

   logic [31:0]     st_addr  [5] = '{32'h403, 32'h402, 32'h7F1, 32'h703, 32'h805};
   lsu_mem_w_type_t st_type  [5] = '{LSU_W_BYTE, LSU_W_HALF, LSU_W_BYTE, LSU_W_HALF, LSU_W_WORD};
   logic [31:0]     st_data  [5] = '{32'h1234_56AB, 32'hABCD_1234, 32'h0000_005A, 32'h0000_BEEF, 32'hDEAD_C0DE};
   logic [3:0]      st_ben   [5] = '{4'b1000, 4'b1100, 4'b0010, 4'b1100, 4'b1111};
   logic [31:0]     st_wdat  [5] = '{32'hABAB_ABAB, 32'h1234_1234, 32'h5A5A_5A5A, 32'hBEEF_BEEF, 32'hDEAD_C0DE};
   logic [31:0]     st_saddr [5] = '{32'h400, 32'h400, 32'h7F0, 32'h700, 32'h804};

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0, td, ti, t, held, extra;
      rst = 1'b1;
      idle_bus();
      bus.mem_address = '0;
      bus.mem_w_data  = '0;
      bus.mem_w_type  = LSU_W_WORD;
      sram_rdata      = '0;
      repeat (3) @(negedge clk);
      chk("rst_ren", {31'd0, sram_ren}, 32'd0);
      chk("rst_wen", {31'd0, sram_wen}, 32'd0);
      chk("rst_ben", {28'd0, sram_ben}, 32'd0);
      chk("rst_rdata", bus.mem_r_data, 32'd0);
      chk("rst_gnt", {30'd0, bus.mem_d_gnt, bus.mem_i_gnt}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Fetch, SRAM ready in the first ACCESS cycle.
      bus.mem_i_ren = 1'b1; bus.mem_address = 32'h100;
      sram_ready = 1'b1; sram_rdata = 32'h13; c0 = cyc;
      @(negedge clk);
      chk("f_ren", {31'd0, sram_ren}, 32'd1);
      chk("f_addr", sram_addr, 32'h100);
      chk("f_ben", {28'd0, sram_ben}, 32'hF);
      chk("f_early_gnt", {31'd0, bus.mem_i_gnt}, 32'd0);
      @(negedge clk);
      chk("f_igtn", {31'd0, bus.mem_i_gnt}, 32'd1);
      chk("f_dgnt", {31'd0, bus.mem_d_gnt}, 32'd0);
      chk("f_rdata", bus.mem_r_data, 32'h13);
      chk("f_latency", cyc - c0, 32'd2);
      chk("f_strobe_drop", {31'd0, sram_ren}, 32'd0);
      idle_bus();
      @(negedge clk);
      chk("f_gnt_pulse", {31'd0, bus.mem_i_gnt}, 32'd0);

      // Fetch and data read together: data goes first, fetch 3 cycles later.
      bus.mem_i_ren = 1'b1; bus.mem_d_ren = 1'b1; bus.mem_address = 32'h300;
      sram_ready = 1'b1; sram_rdata = 32'h55;
      @(negedge clk);
      chk("arb_addr", sram_addr, 32'h300);
      wait_gnt(1'b1, 8, td);
      chk("arb_d_first", {31'd0, bus.mem_i_gnt}, 32'd0);
      chk("arb_d_rdata", bus.mem_r_data, 32'h55);
      bus.mem_d_ren = 1'b0; bus.mem_address = 32'h200; sram_rdata = 32'h66;
      wait_gnt(1'b0, 8, ti);
      chk("arb_gap", ti - td, 32'd3);
      chk("arb_i_rdata", bus.mem_r_data, 32'h66);
      idle_bus();
      @(negedge clk);

      // Stores: lane enables and replicated data.
      for (int i = 0; i < 5; i++) begin
         bus.mem_wen = 1'b1; bus.mem_address = st_addr[i];
         bus.mem_w_type = st_type[i]; bus.mem_w_data = st_data[i];
         @(negedge clk);
         chk($sformatf("st%0d_addr", i), sram_addr, st_saddr[i]);
         chk($sformatf("st%0d_ben", i), {28'd0, sram_ben}, {28'd0, st_ben[i]});
         chk($sformatf("st%0d_wdata", i), sram_wdata, st_wdat[i]);
         chk($sformatf("st%0d_wen", i), {30'd0, sram_wen, sram_ren}, 32'd2);
         sram_ready = 1'b1;
         wait_gnt(1'b1, 4, t);
         chk($sformatf("st%0d_gnt_seen", i), {31'd0, t >= 0}, 32'd1);
         idle_bus();
         @(negedge clk);
      end

      // Delayed ready: strobes held 5 cycles, grant exactly 1 cycle after ready.
      bus.mem_d_ren = 1'b1; bus.mem_address = 32'h500;
      held = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (sram_ren && !bus.mem_d_gnt) held++;
      end
      chk("dly_hold", held, 32'd5);
      sram_ready = 1'b1; sram_rdata = 32'hCAFE_0001;
      @(negedge clk);
      chk("dly_gnt", {31'd0, bus.mem_d_gnt}, 32'd1);
      chk("dly_rdata", bus.mem_r_data, 32'hCAFE_0001);
      chk("dly_ren_drop", {31'd0, sram_ren}, 32'd0);
      sram_ready = 1'b0;
      @(negedge clk);
      chk("dly_gnt_pulse", {31'd0, bus.mem_d_gnt}, 32'd0);
      chk("dly_no_reissue_a", {31'd0, sram_ren}, 32'd0);
      bus.mem_d_ren = 1'b0;
      @(negedge clk);
      chk("dly_no_reissue_b", {31'd0, sram_ren}, 32'd0);

      // Request dropped mid-access: data still captured, grant suppressed.
      bus.mem_d_ren = 1'b1; bus.mem_address = 32'h600;
      @(negedge clk);
      bus.mem_d_ren = 1'b0;
      @(negedge clk);
      sram_ready = 1'b1; sram_rdata = 32'h77;
      @(negedge clk);
      chk("drop_gnt", {30'd0, bus.mem_d_gnt, bus.mem_i_gnt}, 32'd0);
      chk("drop_rdata", bus.mem_r_data, 32'h77);
      sram_ready = 1'b0;
      @(negedge clk);
      chk("drop_gnt_late", {30'd0, bus.mem_d_gnt, bus.mem_i_gnt}, 32'd0);

      // Write and read together: serviced as a write, read data untouched.
      bus.mem_wen = 1'b1; bus.mem_d_ren = 1'b1; bus.mem_address = 32'h900;
      bus.mem_w_type = LSU_W_WORD; bus.mem_w_data = 32'h1122_3344; sram_rdata = 32'h99;
      @(negedge clk);
      chk("wr_rd_strobes", {30'd0, sram_wen, sram_ren}, 32'd2);
      sram_ready = 1'b1;
      wait_gnt(1'b1, 4, t);
      chk("wr_rd_gnt_seen", {31'd0, t >= 0}, 32'd1);
      chk("wr_rd_rdata_kept", bus.mem_r_data, 32'h77);
      idle_bus();
      @(negedge clk);

      // Reset during ACCESS abandons the access.
      bus.mem_i_ren = 1'b1; bus.mem_address = 32'hA00;
      @(negedge clk);
      chk("rst_acc_ren", {31'd0, sram_ren}, 32'd1);
      rst = 1'b1; bus.mem_i_ren = 1'b0;
      @(negedge clk);
      chk("rst_acc_strobes", {30'd0, sram_wen, sram_ren}, 32'd0);
      chk("rst_acc_rdata", bus.mem_r_data, 32'd0);
      rst = 1'b0; sram_ready = 1'b1;
      extra = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (bus.mem_i_gnt || bus.mem_d_gnt || sram_ren) extra++;
      end
      chk("rst_acc_no_gnt", extra, 32'd0);
      idle_bus();
      @(negedge clk);

`ifdef LSU_TIMEOUT_EN
      // No sram_ready: abort after 8 ACCESS cycles.
      bus.mem_i_ren = 1'b1; bus.mem_address = 32'hB00; c0 = cyc;
      wait_gnt(1'b0, 20, t);
      chk("to_latency", t - c0, 32'd9);
      chk("to_err", {31'd0, lsu_err}, 32'd1);
      chk("to_rdata", bus.mem_r_data, 32'hDEAD_BEEF);
      chk("to_strobes", {31'd0, sram_ren}, 32'd0);
      bus.mem_i_ren = 1'b0;
      @(negedge clk);
      chk("to_err_pulse", {31'd0, lsu_err}, 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
